// File: rtl/vslc_fetch.sv
// Instruction fetch for the VSLC executor: streams the ladder program from an
// SPI memory (mode 0, READ 0x03 from address 0) and presents it a byte at a time.
module vslc_fetch #(
    parameter int         ADDR_BITS  = 16,
    parameter logic [7:0] END_OPCODE = 8'hFF,
    parameter int         MAX_LEN    = 256,
    parameter int         GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [7:0]  ui_in,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic [7:0]  instr,
    output logic        instr_ready,
    output logic [7:0]  ui_cur,
    output logic [7:0]  ui_prev,
    output logic [15:0] counter,
    output logic        scan_start
);

    localparam int CMD_BITS = 8 + ADDR_BITS;
    localparam int CMD_CYC  = 2 * CMD_BITS;
    localparam int CNT_LIM  = (CMD_CYC > GAP_CYCLES) ? CMD_CYC : GAP_CYCLES;
    localparam int CNT_W    = $clog2(CNT_LIM + 1);
    localparam int BCNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CMD_BITS-1:0] CMD_WORD = {8'h03, {ADDR_BITS{1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_CMD     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CMD_BITS-1:0] tx_q, tx_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          instr_q, instr_d;
    logic [7:0]          ui_cur_q, ui_cur_d;
    logic [7:0]          ui_prev_q, ui_prev_d;
    logic [15:0]         counter_q, counter_d;
    logic                sck_q, sck_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                instr_ready_q, instr_ready_d;
    logic                scan_start_q, scan_start_d;
    logic [7:0]          rx_byte_s;
    logic                start_s;

    // Next-state logic; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        instr_d    = instr_q;
        counter_d  = counter_q + 16'd1;
        rx_byte_s  = {rx_q[6:0], spi_miso};

        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_W'(0);
                if (run) state_d = S_START;
                else     state_d = S_IDLE;
            end
            S_START: begin
                cnt_d   = CNT_W'(0);
                state_d = S_CMD;
            end
            S_CMD: begin
                if (cnt_q == CNT_W'(CMD_CYC - 1)) begin
                    cnt_d   = CNT_W'(0);
                    state_d = S_DATA;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_DATA: begin
                // miso is captured on the edge that ends the sck-high phase
                if (cnt_q[0]) rx_d = rx_byte_s;
                else          rx_d = rx_q;
                if (cnt_q == CNT_W'(15)) begin
                    cnt_d = CNT_W'(0);
                    if (rx_byte_s == END_OPCODE) begin
                        state_d = S_GAP;
                    end else begin
                        state_d    = S_PRESENT;
                        instr_d    = rx_byte_s;
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PRESENT: begin
                if (cnt_q == CNT_W'(2)) begin
                    cnt_d = CNT_W'(0);
                    if (byte_cnt_q == BCNT_W'(MAX_LEN)) state_d = S_GAP;
                    else if (!run)                      state_d = S_GAP;
                    else                                state_d = S_DATA;
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = CNT_W'(0);
                    if (run) state_d = S_START;
                    else     state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                cnt_d   = CNT_W'(0);
                state_d = S_IDLE;
            end
        endcase

        // Snapshot, pulse and counter clear all land together on entry to START
        start_s      = (state_d == S_START);
        scan_start_d = start_s;
        ui_cur_d     = start_s ? ui_in    : ui_cur_q;
        ui_prev_d    = start_s ? ui_cur_q : ui_prev_q;
        byte_cnt_d   = start_s ? BCNT_W'(0) : byte_cnt_d;

        if (start_s)                              tx_d = CMD_WORD;
        else if ((state_q == S_CMD) && cnt_q[0])  tx_d = {tx_q[CMD_BITS-2:0], 1'b0};
        else                                      tx_d = tx_q;

        cs_n_d        = (state_d == S_IDLE) || (state_d == S_GAP) || (state_d == S_START && 1'b0);
        cs_n_d        = (state_d == S_IDLE) || (state_d == S_GAP);
        sck_d         = ((state_d == S_CMD) || (state_d == S_DATA)) && cnt_d[0];
        mosi_d        = (state_d == S_CMD) && tx_d[CMD_BITS-1];
        instr_ready_d = (state_d == S_PRESENT) && (cnt_d < CNT_W'(2));
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= CNT_W'(0);
            byte_cnt_q    <= BCNT_W'(0);
            tx_q          <= {CMD_BITS{1'b0}};
            rx_q          <= 8'h00;
            instr_q       <= 8'h00;
            ui_cur_q      <= 8'h00;
            ui_prev_q     <= 8'h00;
            counter_q     <= 16'h0000;
            sck_q         <= 1'b0;
            cs_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            instr_ready_q <= 1'b0;
            scan_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            instr_q       <= instr_d;
            ui_cur_q      <= ui_cur_d;
            ui_prev_q     <= ui_prev_d;
            counter_q     <= counter_d;
            sck_q         <= sck_d;
            cs_n_q        <= cs_n_d;
            mosi_q        <= mosi_d;
            instr_ready_q <= instr_ready_d;
            scan_start_q  <= scan_start_d;
        end
    end

    assign spi_sck     = sck_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_mosi    = mosi_q;
    assign instr       = instr_q;
    assign instr_ready = instr_ready_q;
    assign ui_cur      = ui_cur_q;
    assign ui_prev     = ui_prev_q;
    assign counter     = counter_q;
    assign scan_start  = scan_start_q;

endmodule

// File: tb/tb_vslc_fetch.sv
// Scoreboard bench for vslc_fetch: SPI memory model, expected-value queues and
// a monitor that checks bytes, command words, scan snapshots and gap lengths.
module tb_vslc_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic        spi_miso = 1'b0;
    logic        spi_sck, spi_cs_n, spi_mosi;
    logic [7:0]  instr, ui_cur, ui_prev;
    logic        instr_ready, scan_start;
    logic [15:0] counter;

    vslc_fetch #(
        .ADDR_BITS(16), .END_OPCODE(8'hFF), .MAX_LEN(4), .GAP_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ui_in(ui_in), .spi_miso(spi_miso),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .instr(instr), .instr_ready(instr_ready), .ui_cur(ui_cur), .ui_prev(ui_prev),
        .counter(counter), .scan_start(scan_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_scan[$];
    logic [7:0]  exp_instr[$];
    logic [23:0] exp_cmd[$];
    int          exp_gap[$];
    logic [7:0]  mem[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // SPI memory: captures the command on sck rise, drives data bits right after sck rise
    int          bit_cnt = 0;
    logic [23:0] cmd_sr = 24'h0;
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            bit_cnt  = 0;
            spi_miso = 1'b0;
        end else begin
            if (bit_cnt < 24) begin
                cmd_sr = {cmd_sr[22:0], spi_mosi};
                if (bit_cnt == 23) begin
                    if (exp_cmd.size() == 0) check("unexpected_cmd", cmd_sr, 24'hxxxxxx);
                    else check("cmd_word", cmd_sr, exp_cmd.pop_front());
                end
            end else begin
                int idx;
                logic [7:0] b;
                idx = bit_cnt - 24;
                b = mem[(idx >> 3) & 15];
                spi_miso = b[7 - (idx & 7)];
            end
            bit_cnt++;
        end
    end

    // Monitor: samples on the falling clk edge and pops expectations as outputs appear
    int          scans = 0, seen = 0, cyc_in_scan = 0, last_cyc = 0, rdy_len = 0, cs_hi = 0;
    bit          have_last = 1'b0, prev_rdy = 1'b0, prev_cs = 1'b1;
    logic [15:0] cur_exp = 16'h0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy  = 1'b0;
            prev_cs   = 1'b1;
            cs_hi     = 0;
            rdy_len   = 0;
            have_last = 1'b0;
        end else begin
            cyc_in_scan++;
            if (scan_start) begin
                scans++;
                cyc_in_scan = 0;
                have_last   = 1'b0;
                if (exp_scan.size() == 0) begin
                    check("unexpected_scan_start", 32'd1, 32'd0);
                end else begin
                    cur_exp = exp_scan.pop_front();
                    check("scan_ui_cur", ui_cur, cur_exp[15:8]);
                    check("scan_ui_prev", ui_prev, cur_exp[7:0]);
                end
            end
            if (instr_ready && !prev_rdy) begin
                seen++;
                if (exp_instr.size() == 0) check("unexpected_instr", instr, 32'hxx);
                else check("instr", instr, exp_instr.pop_front());
                check("instr_ui_cur", ui_cur, cur_exp[15:8]);
                check("instr_ui_prev", ui_prev, cur_exp[7:0]);
                if (!have_last) check("first_byte_latency", cyc_in_scan, 65);
                else            check("byte_cadence", cyc_in_scan - last_cyc, 19);
                last_cyc  = cyc_in_scan;
                have_last = 1'b1;
                rdy_len   = 0;
            end
            if (instr_ready) rdy_len++;
            if (!instr_ready && prev_rdy) check("instr_ready_width", rdy_len, 2);
            if (spi_cs_n) begin
                cs_hi++;
            end else begin
                if (prev_cs && exp_gap.size() != 0) check("gap_len", cs_hi, exp_gap.pop_front());
                cs_hi = 0;
            end
            prev_rdy = instr_ready;
            prev_cs  = spi_cs_n;
        end
    end

    task automatic wait_seen(input int n);
        int k = 0;
        while (seen < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("wait_instr_count", seen, n);
    endtask

    task automatic wait_scan(input int n);
        int k = 0;
        while (scans < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("wait_scan_count", scans, n);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset held 3 cycles in the middle of a DATA byte
        mem[0] = 8'h11;
        ui_in  = 8'h77;
        exp_scan.push_back({8'h77, 8'h00});
        exp_cmd.push_back(24'h030000);
        run = 1'b1;
        wait_scan(1);
        repeat (55) @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_instr", instr, 8'h00);
        check("rst_instr_ready", instr_ready, 1'b0);
        check("rst_counter", counter, 16'h0000);
        check("rst_ui_cur", ui_cur, 8'h00);
        check("rst_ui_prev", ui_prev, 8'h00);
        check("rst_scan_start", scan_start, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("counter_after_reset", counter, 16'd5);

        // Two scans of 0x05,0x83,END with input snapshots 0xA5 then 0x3C
        mem[0] = 8'h05; mem[1] = 8'h83; mem[2] = 8'hFF;
        ui_in  = 8'hA5;
        exp_scan.push_back({8'hA5, 8'h00});
        exp_cmd.push_back(24'h030000);
        exp_instr.push_back(8'h05);
        exp_instr.push_back(8'h83);
        run = 1'b1;
        wait_seen(1);
        exp_gap.push_back(4);
        exp_scan.push_back({8'h3C, 8'hA5});
        exp_cmd.push_back(24'h030000);
        exp_instr.push_back(8'h05);
        exp_instr.push_back(8'h83);
        wait_seen(2);
        ui_in = 8'h3C;
        wait_scan(3);
        ui_in = 8'h5A;
        wait_seen(3);
        ui_in = 8'hC3;
        wait_seen(4);
        run = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_cs_n_a", spi_cs_n, 1'b1);
        check("scan_count_a", scans, 3);

        // run dropped at bit 3 of byte 0x11: byte still presented, then idle
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hFF;
        ui_in  = 8'h96;
        exp_scan.push_back({8'h96, 8'h3C});
        exp_cmd.push_back(24'h030000);
        exp_instr.push_back(8'h11);
        run = 1'b1;
        wait_scan(4);
        repeat (55) @(negedge clk);
        run = 1'b0;
        wait_seen(5);
        repeat (40) @(negedge clk);
        check("idle_cs_n_b", spi_cs_n, 1'b1);
        check("idle_sck_b", spi_sck, 1'b0);
        check("scan_count_b", scans, 4);
        check("instr_held", instr, 8'h11);

        // No END in memory: MAX_LEN=4 forces a restart at address 0
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        ui_in = 8'h69;
        exp_scan.push_back({8'h69, 8'h96});
        exp_cmd.push_back(24'h030000);
        for (int i = 1; i <= 4; i++) exp_instr.push_back(8'(i));
        run = 1'b1;
        wait_seen(6);
        exp_gap.push_back(4);
        exp_scan.push_back({8'h69, 8'h69});
        exp_cmd.push_back(24'h030000);
        exp_instr.push_back(8'h01);
        exp_instr.push_back(8'h02);
        wait_seen(10);
        repeat (5) @(negedge clk);
        run = 1'b0;
        wait_seen(11);
        repeat (40) @(negedge clk);
        check("idle_cs_n_c", spi_cs_n, 1'b1);
        check("scan_count_c", scans, 6);
        check("left_instr", exp_instr.size(), 0);
        check("left_scan", exp_scan.size(), 0);
        check("left_cmd", exp_cmd.size(), 0);
        check("left_gap", exp_gap.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
